// File: rtl/du_pkg.sv
// Shared encodings for the debug-unit dump sequencer: FSM states, dump
// segments and the byte-per-word geometry of the serialiser.
package du_pkg;

  localparam int STATE_W        = 4;
  localparam int BYTES_PER_WORD = 4;
  localparam int BCNT_W         = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_ADDR    = 4'd1,
    ST_WAIT    = 4'd2,
    ST_LATCH   = 4'd3,
    ST_SEND    = 4'd4,
    ST_WAIT_TX = 4'd5,
    ST_DONE    = 4'd6
  } state_t;

  typedef enum logic [1:0] {
    SEG_PC = 2'd0,
    SEG_RB = 2'd1,
    SEG_DM = 2'd2
  } seg_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Width of an index that must reach n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/word_serializer.sv
// Word-to-byte serialiser: loads a word, presents its top byte, and shifts
// left one byte per request while counting the bytes already consumed.
module word_serializer
  import du_pkg::*;
#(
  parameter int W = 32,
  parameter int B = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] word,
  input  logic         shift,
  output logic [B-1:0] data_byte,
  output logic         last
);

  logic [W-1:0]      shreg;
  logic [BCNT_W-1:0] cnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      cnt   <= '0;
    end else if (load) begin
      shreg <= word;
      cnt   <= '0;
    end else if (shift) begin
      shreg <= shreg << B;
      cnt   <= cnt + 1'b1;
    end
  end

  assign data_byte = shreg[W-1 -: B];
  // High while the byte on data_byte is the final one of the word.
  assign last      = (cnt == BCNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/du_dump_sequencer.sv
// Debug dump sequencer: on a start pulse streams PC, register bank and data
// memory to the UART, four bytes per word, MSB first.
module du_dump_sequencer
  import du_pkg::*;
#(
  parameter int BYTE        = 8,
  parameter int DWORD       = 32,
  parameter int RB_ADDR     = 5,
  parameter int DM_ADDR     = 5,
  parameter int NB_RB_WORDS = 32,
  parameter int NB_DM_WORDS = 32,
  parameter int NB_STATE    = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_tx_done,
  input  logic [DWORD-1:0]    i_pc_value,
  input  logic [DWORD-1:0]    i_rb_data,
  input  logic [DWORD-1:0]    i_dm_data,
  output logic [RB_ADDR-1:0]  o_rb_addr,
  output logic                o_rb_read_enable,
  output logic [DM_ADDR-1:0]  o_dm_addr,
  output logic                o_dm_read_enable,
  output logic                o_dm_du_flag,
  output logic [BYTE-1:0]     o_tx_data,
  output logic                o_tx_start,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_STATE-1:0] o_state
);

  localparam int IDX_W = idx_width(max_int(NB_RB_WORDS, NB_DM_WORDS));
  localparam logic [IDX_W-1:0] RB_LAST = IDX_W'(NB_RB_WORDS - 1);
  localparam logic [IDX_W-1:0] DM_LAST = IDX_W'(NB_DM_WORDS - 1);

  state_t           state, state_next;
  seg_t             seg, seg_next;
  logic [IDX_W-1:0] index, index_next;

  logic             load;
  logic             shift;
  logic             last_byte;
  logic             reading;
  logic [DWORD-1:0] capture_word;
  logic [BYTE-1:0]  tx_byte;

  // Handshake: o_tx_start is a one-cycle request in SEND; the transmitter
  // answers with a one-cycle i_tx_done, which only WAIT_TX consumes.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state <= ST_IDLE;
      seg   <= SEG_PC;
      index <= '0;
    end else begin
      state <= state_next;
      seg   <= seg_next;
      index <= index_next;
    end
  end

  always_comb begin
    state_next = state;
    seg_next   = seg;
    index_next = index;
    load       = 1'b0;
    shift      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_ADDR;
          seg_next   = SEG_PC;
          index_next = '0;
        end
      end
      // The PC is a live register value, so it needs no read latency.
      ST_ADDR:  state_next = (seg == SEG_PC) ? ST_LATCH : ST_WAIT;
      ST_WAIT:  state_next = ST_LATCH;
      ST_LATCH: begin
        load       = 1'b1;
        state_next = ST_SEND;
      end
      ST_SEND:  state_next = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          shift = 1'b1;
          if (!last_byte) begin
            state_next = ST_SEND;
          end else begin
            state_next = ST_ADDR;
            index_next = index + 1'b1;
            case (seg)
              SEG_PC: begin
                seg_next   = SEG_RB;
                index_next = '0;
              end
              SEG_RB: begin
                if (index == RB_LAST) begin
                  seg_next   = SEG_DM;
                  index_next = '0;
                end
              end
              SEG_DM: begin
                if (index == DM_LAST) begin
                  state_next = ST_DONE;
                  index_next = '0;
                end
              end
              default: state_next = ST_IDLE;
            endcase
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
        seg_next   = SEG_PC;
        index_next = '0;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    capture_word = '0;
    case (seg)
      SEG_PC:  capture_word = i_pc_value;
      SEG_RB:  capture_word = i_rb_data;
      SEG_DM:  capture_word = i_dm_data;
      default: capture_word = '0;
    endcase
  end

  word_serializer #(
    .W (DWORD),
    .B (BYTE)
  ) u_serializer (
    .clock     (i_clock),
    .rst_n     (i_reset),
    .load      (load),
    .word      (capture_word),
    .shift     (shift),
    .data_byte (tx_byte),
    .last      (last_byte)
  );

  // Addresses and strobes are only exposed in ADDR/WAIT so the datapath
  // sees a quiet bus whenever no read is in flight.
  assign reading          = (state == ST_ADDR) || (state == ST_WAIT);
  assign o_rb_read_enable = reading && (seg == SEG_RB);
  assign o_dm_read_enable = reading && (seg == SEG_DM);
  assign o_rb_addr        = o_rb_read_enable ? RB_ADDR'(index) : '0;
  assign o_dm_addr        = o_dm_read_enable ? DM_ADDR'(index) : '0;
  assign o_dm_du_flag     = (seg == SEG_DM) && (state != ST_IDLE) && (state != ST_DONE);
  assign o_tx_data        = tx_byte;
  assign o_tx_start       = (state == ST_SEND);
  assign o_busy           = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done           = (state == ST_DONE);
  assign o_state          = NB_STATE'(state);

endmodule

// File: tb/tb_du_dump_sequencer.sv
// Bench for du_dump_sequencer: behavioural byte-stream model with randomized
// memory contents, TX latencies and spurious handshakes, plus a small instance.
module tb_du_dump_sequencer;

  localparam int NRB    = 32;
  localparam int NDM    = 32;
  localparam int TOTAL  = 4 * (1 + NRB + NDM);
  localparam int NRB2   = 2;
  localparam int NDM2   = 1;
  localparam int TOTAL2 = 4 * (1 + NRB2 + NDM2);

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic        start = 1'b0;
  logic        tx_done_resp = 1'b0;
  logic        tx_done_spur = 1'b0;
  logic        tx_done;
  logic [31:0] pc_val;
  logic [31:0] rb_data = '0;
  logic [31:0] dm_data = '0;
  logic [4:0]  rb_addr, dm_addr;
  logic        rb_en, dm_en, du_flag;
  logic [7:0]  tx_data;
  logic        tx_start, busy, done;
  logic [3:0]  state;

  logic        start2 = 1'b0;
  logic        tx_done2 = 1'b0;
  logic [31:0] rb_data2 = '0;
  logic [31:0] dm_data2 = '0;
  logic [4:0]  rb_addr2, dm_addr2;
  logic        rb_en2, dm_en2, du_flag2;
  logic [7:0]  tx_data2;
  logic        tx_start2, busy2, done2;
  logic [3:0]  state2;

  logic [31:0] rb_mem [NRB];
  logic [31:0] dm_mem [NDM];

  assign tx_done = tx_done_resp | tx_done_spur;

  du_dump_sequencer dut (
    .i_clock(clk), .i_reset(rst_n), .i_start(start), .i_tx_done(tx_done),
    .i_pc_value(pc_val), .i_rb_data(rb_data), .i_dm_data(dm_data),
    .o_rb_addr(rb_addr), .o_rb_read_enable(rb_en), .o_dm_addr(dm_addr),
    .o_dm_read_enable(dm_en), .o_dm_du_flag(du_flag), .o_tx_data(tx_data),
    .o_tx_start(tx_start), .o_busy(busy), .o_done(done), .o_state(state)
  );

  du_dump_sequencer #(.NB_RB_WORDS(NRB2), .NB_DM_WORDS(NDM2)) dut2 (
    .i_clock(clk), .i_reset(rst_n), .i_start(start2), .i_tx_done(tx_done2),
    .i_pc_value(pc_val), .i_rb_data(rb_data2), .i_dm_data(dm_data2),
    .o_rb_addr(rb_addr2), .o_rb_read_enable(rb_en2), .o_dm_addr(dm_addr2),
    .o_dm_read_enable(dm_en2), .o_dm_du_flag(du_flag2), .o_tx_data(tx_data2),
    .o_tx_start(tx_start2), .o_busy(busy2), .o_done(done2), .o_state(state2)
  );

  // Datapath read ports: one cycle of latency; DM answers garbage unless the
  // DU address select is active.
  always @(posedge clk) begin
    if (rb_en)  rb_data  <= rb_mem[rb_addr];
    if (dm_en)  dm_data  <= du_flag ? dm_mem[dm_addr] : 32'hBAD0_BAD0;
    if (rb_en2) rb_data2 <= rb_mem[rb_addr2 % NRB];
    if (dm_en2) dm_data2 <= du_flag2 ? dm_mem[dm_addr2 % NDM] : 32'hBAD0_BAD0;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, actual, expected);
    end
  endtask

  // Byte k of a dump: word k/4 is PC, then RB words, then DM words; MSB first.
  function automatic logic [7:0] exp_byte(input int k, input int nrb);
    int w;
    logic [31:0] v;
    w = k / 4;
    if (w == 0)        v = pc_val;
    else if (w <= nrb) v = rb_mem[w - 1];
    else               v = dm_mem[(w - 1 - nrb) % NDM];
    return 8'(v >> (8 * (3 - (k % 4))));
  endfunction

  // ---------------- behavioural model (posedge) ----------------
  // phase: 0 idle, 1 dumping, 2 completion cycle
  int phase = 0;
  int acc   = 0;
  int cyc   = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = 0;
      acc   = 0;
      cyc   = 0;
    end else begin
      case (phase)
        0: if (start) begin phase = 1; acc = 0; cyc = 0; end
        1: begin
          cyc++;
          if (tx_done_resp) begin
            acc++;
            if (acc == TOTAL) phase = 2;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  // ---------------- TX responder ----------------
  int lo = 5;
  int hi = 5;
  int resp_cnt = -1;

  always @(negedge clk) begin
    tx_done_resp = 1'b0;
    if (!rst_n) resp_cnt = -1;
    else if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        tx_done_resp = 1'b1;
        resp_cnt = -1;
      end
    end
    if (rst_n && tx_start) resp_cnt = $urandom_range(hi, lo);
  end

  // Spurious tx_done in IDLE (0), LATCH (3) or SEND (tx_start high).
  bit spur_en = 1'b0;
  always @(negedge clk) begin
    tx_done_spur = spur_en && rst_n && (state == 4'd0 || state == 4'd3 || tx_start)
                   && ($urandom_range(2, 0) == 0);
  end

  // ---------------- scoreboard / compare (negedge) ----------------
  logic [7:0] exp_q[$];
  logic [7:0] byte_log[$];
  logic [7:0] cur_byte = '0;
  int  nstart = 0;
  int  done_cnt = 0;
  int  en_cnt = 0;
  int  addr_cyc = 0;
  int  prev_phase = 0;
  bit  prev_start = 1'b0;
  bit  prev_en = 1'b0;

  always @(negedge clk) begin
    int w;
    if (!rst_n) begin
      check("reset_outputs", {4'd0, rb_addr, rb_en, dm_addr, dm_en, du_flag, tx_data,
                              tx_start, busy, done, state}, 32'd0);
      prev_phase = 0;
      prev_start = 1'b0;
      prev_en    = 1'b0;
    end else begin
      if (phase == 1 && prev_phase == 0) begin
        nstart = 0; done_cnt = 0; en_cnt = 0;
        byte_log.delete();
        exp_q.delete();
        for (int k = 0; k < TOTAL; k++) exp_q.push_back(exp_byte(k, NRB));
      end
      w = acc / 4;
      check("busy", 32'(busy), 32'(phase == 1));
      check("done", 32'(done), 32'(phase == 2));
      check("du_flag", 32'(du_flag), 32'(phase == 1 && w >= 1 + NRB));
      if (phase == 0) check("state_idle", 32'(state), 32'd0);
      if (phase == 2) begin
        check("state_done", 32'(state), 32'd6);
        done_cnt++;
      end
      if (phase != 1) check("quiet_when_idle", 32'({rb_en, dm_en, tx_start}), 32'd0);
      if (rb_en) begin
        check("rb_read_in_rb_word", 32'(w >= 1 && w <= NRB), 32'd1);
        check("rb_addr", 32'(rb_addr), 32'(w - 1));
        check("rb_dm_exclusive", 32'(dm_en), 32'd0);
        if (!prev_en) addr_cyc = cyc;
        en_cnt++;
      end
      if (dm_en) begin
        check("dm_read_in_dm_word", 32'(w > NRB), 32'd1);
        check("dm_addr", 32'(dm_addr), 32'(w - 1 - NRB));
        if (!prev_en) addr_cyc = cyc;
        en_cnt++;
      end
      if (tx_start) begin
        check("tx_start_one_cycle", 32'(prev_start), 32'd0);
        check("tx_after_prev_done", 32'(nstart), 32'(acc));
        if (exp_q.size() == 0) begin
          check("stream_overrun", 32'(nstart + 1), 32'(TOTAL));
        end else begin
          cur_byte = exp_q.pop_front();
          check("tx_byte", 32'(tx_data), 32'(cur_byte));
        end
        byte_log.push_back(tx_data);
        if (nstart % 4 == 0) begin
          if (nstart == 0) begin
            check("pc_latency", 32'(cyc), 32'd2);
            check("pc_no_read", 32'(en_cnt), 32'd0);
          end else begin
            check("read_latency", 32'(cyc - addr_cyc), 32'd3);
            check("read_enable_cycles", 32'(en_cnt), 32'd2);
          end
          en_cnt = 0;
        end
        nstart++;
      end else if (phase == 1 && nstart > acc) begin
        check("tx_data_hold", 32'(tx_data), 32'(cur_byte));
      end
      prev_start = tx_start;
      prev_en    = rb_en || dm_en;
      prev_phase = phase;
    end
  end

  // ---------------- small instance: collector and responder ----------------
  int n2 = 0;
  int done2_cnt = 0;
  int r2_cnt = -1;
  int p2 = 0;
  bit expect_done2 = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_start2) begin
        check("small_tx_byte", 32'(tx_data2), 32'(exp_byte(n2, NRB2)));
        n2++;
      end
      if (done2) done2_cnt++;
      if (rb_en2) check("small_rb_addr_range", 32'(rb_addr2 < NRB2), 32'd1);
      if (dm_en2) check("small_dm_read", 32'({dm_addr2, du_flag2}), 32'd1);
    end
  end

  always @(negedge clk) begin
    tx_done2 = 1'b0;
    if (expect_done2) begin
      check("small_done_after_last", 32'(done2), 32'd1);
      expect_done2 = 1'b0;
    end
    if (r2_cnt > 0) begin
      r2_cnt--;
      if (r2_cnt == 0) begin
        tx_done2 = 1'b1;
        r2_cnt = -1;
        p2++;
        if (p2 == TOTAL2) expect_done2 = 1'b1;
      end
    end
    if (rst_n && tx_start2) r2_cnt = 3;
  end

  // ---------------- driver tasks ----------------
  task automatic run_dump(input int poke_at, input int reset_at);
    bit poked;
    bit finished;
    poked = 1'b0;
    finished = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 8000 && !finished; c++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) finished = 1'b1;
      else if (reset_at >= 0 && nstart >= reset_at) begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        finished = 1'b1;
      end else if (poke_at >= 0 && !poked && nstart >= poke_at) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        poked = 1'b1;
      end
    end
    if (!finished) check("dump_timeout", 32'd0, 32'd1);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic randomize_memories();
    pc_val = $urandom;
    for (int i = 0; i < NRB; i++) rb_mem[i] = $urandom;
    for (int i = 0; i < NDM; i++) dm_mem[i] = $urandom;
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] lit12 [12] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};

  initial begin
    pc_val = 32'hDEAD_BEEF;
    for (int i = 0; i < NRB; i++) rb_mem[i] = i;
    for (int i = 0; i < NDM; i++) dm_mem[i] = 32'h100 + i;

    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;

    // Pin the model to hand-computed bytes of the reference dump.
    check("model_b0",   32'(exp_byte(0, NRB)),   32'hDE);
    check("model_b3",   32'(exp_byte(3, NRB)),   32'hEF);
    check("model_b11",  32'(exp_byte(11, NRB)),  32'h01);
    check("model_b131", 32'(exp_byte(131, NRB)), 32'h1F);
    check("model_b134", 32'(exp_byte(134, NRB)), 32'h01);
    check("model_b259", 32'(exp_byte(259, NRB)), 32'h1F);

    // Dump 1: reference contents, tx_done 5 cycles after each start.
    run_dump(-1, -1);
    for (int i = 0; i < 12; i++)
      check("lit_stream", 32'((byte_log.size() > i) ? byte_log[i] : 8'hXX), 32'(lit12[i]));
    check("dump1_bytes", 32'(nstart), 32'(TOTAL));
    check("dump1_done_once", 32'(done_cnt), 32'd1);
    check("dump1_idle", 32'({busy, state}), 32'd0);

    // Dump 2: random contents and latencies, spurious tx_done, restart poke.
    randomize_memories();
    lo = 1;
    hi = 6;
    spur_en = 1'b1;
    run_dump(50, -1);
    spur_en = 1'b0;
    check("dump2_bytes", 32'(nstart), 32'(TOTAL));
    check("dump2_done_once", 32'(done_cnt), 32'd1);
    check("dump2_queue_empty", 32'(exp_q.size()), 32'd0);

    // Dump 3: reset mid-stream, then restart from the PC.
    randomize_memories();
    pc_val = 32'hDEAD_BEEF;
    run_dump(-1, 100);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    repeat (8) @(negedge clk);
    run_dump(-1, -1);
    check("restart_first_byte", 32'((byte_log.size() > 0) ? byte_log[0] : 8'hXX), 32'hDE);
    check("restart_bytes", 32'(nstart), 32'(TOTAL));
    check("restart_done_once", 32'(done_cnt), 32'd1);

    // Small instance: 2 RB words, 1 DM word.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    for (int c = 0; c < 1000 && done2_cnt == 0; c++) begin
      @(negedge clk);
      #1;
    end
    repeat (4) @(negedge clk);
    #1;
    check("small_bytes", 32'(n2), 32'(TOTAL2));
    check("small_done_once", 32'(done2_cnt), 32'd1);
    check("small_idle", 32'({busy2, state2}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
